// File: rtl/uart_seq_pkg.sv
// uart_seq_pkg
// Shared definitions for the UART transmit sequencer:
//   - seq_state_e : sequencer FSM states
//   - control-register field positions and the CFG / LOAD write masks
//   - uart_cfg_t  : shadow copy of the line configuration and its reset value
//   - cfg_word / load_word : control-register images written by the sequencer
package uart_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_LOAD,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } seq_state_e;

  localparam int CTL_W      = 19;
  localparam int DATA_MSB   = 18;
  localparam int DATA_LSB   = 11;
  localparam int TX_EN_BIT  = 10;
  localparam int BAUD_MSB   = 9;
  localparam int BAUD_LSB   = 6;
  localparam int STOP_BIT   = 5;
  localparam int PARITY_MSB = 4;
  localparam int PARITY_LSB = 3;
  localparam int FRAME_MSB  = 2;
  localparam int FRAME_LSB  = 1;
  localparam int ON_BIT     = 0;

  // CFG touches the line settings and the enable; LOAD touches the byte,
  // tx_en and the enable, leaving the line settings alone.
  localparam logic [CTL_W-1:0] CFG_WMASK  = 19'h003FF;
  localparam logic [CTL_W-1:0] LOAD_WMASK = 19'h7FC01;

  typedef struct packed {
    logic [3:0] baud;
    logic       stop;
    logic [1:0] parity;
    logic [1:0] frame;
  } uart_cfg_t;

  localparam uart_cfg_t DEFAULT_CFG = '{baud: 4'd7, stop: 1'b0, parity: 2'b00, frame: 2'b11};

  function automatic logic [CTL_W-1:0] cfg_word(input uart_cfg_t c);
    logic [CTL_W-1:0] w;
    w = '0;
    w[BAUD_MSB:BAUD_LSB]     = c.baud;
    w[STOP_BIT]              = c.stop;
    w[PARITY_MSB:PARITY_LSB] = c.parity;
    w[FRAME_MSB:FRAME_LSB]   = c.frame;
    w[ON_BIT]                = 1'b1;
    return w;
  endfunction

  function automatic logic [CTL_W-1:0] load_word(input uart_cfg_t c, input logic [7:0] b);
    logic [CTL_W-1:0] w;
    w = cfg_word(c);
    w[DATA_MSB:DATA_LSB] = b;
    w[TX_EN_BIT]         = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_sequencer_arbiter.sv
// uart_rr_arbiter
// Combinational round-robin picker. The requester after ptr has the highest
// priority, wrapping modulo NUM_REQ; ptr itself has the lowest.
// Ports:
//   req   : request vector
//   ptr   : index of the most recently granted requester
//   grant : one-hot grant (all zero when no request)
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W:0] sum;

  // Scan from lowest priority to highest so the highest-priority hit is the
  // one left standing.
  always_comb begin
    grant = '0;
    sum   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      if (req[sum[ID_W-1:0]]) begin
        grant                 = '0;
        grant[sum[ID_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
// Arbitrates NUM_REQ byte requesters onto one UART and sequences the UART
// control-register writes: a CFG write for line-setting updates, a LOAD write
// per byte, then waits for the tx-busy flag to rise and fall.
// Optional feature: define UART_SEQ_TIMEOUT_EN to bound WAIT_BUSY to
// TIMEOUT_CYCLES cycles, raising sticky timeout_err on expiry.
// Ports:
//   clk, arst                 : clock, asynchronous active-high reset
//   req_valid/req_data        : per-requester byte requests (byte i at [8i+7:8i])
//   req_ready                 : one-hot accept pulse
//   grant_id                  : index of last accepted requester
//   cfg_valid/cfg_*/cfg_ready : configuration update handshake
//   ctl_reg_we/wdata/wmask    : UART control-register write port
//   st_reg_re/rmask/rdata     : UART status-register read port
//   busy                      : sequencer not idle
//   timeout_err               : sticky WAIT_BUSY timeout flag
module uart_tx_sequencer
  import uart_seq_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TX_BUSY_BIT    = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  input  logic                       cfg_valid,
  input  logic [3:0]                 cfg_baud,
  input  logic                       cfg_stop,
  input  logic [1:0]                 cfg_parity,
  input  logic [1:0]                 cfg_frame,
  output logic                       cfg_ready,
  output logic                       ctl_reg_we,
  output logic [18:0]                ctl_reg_wdata,
  output logic [18:0]                ctl_reg_wmask,
  output logic                       st_reg_re,
  output logic [11:0]                st_reg_rmask,
  input  logic [11:0]                st_reg_rdata,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  seq_state_e          state_reg, state_next;
  logic [ID_W-1:0]     ptr_reg;
  logic [ID_W-1:0]     grant_id_reg;
  logic [7:0]          byte_reg;
  uart_cfg_t           shadow_reg;

  logic [NUM_REQ-1:0]  grant_vec;
  logic [ID_W-1:0]     grant_idx;
  logic [7:0]          req_byte [NUM_REQ];
  logic                tx_busy;
  logic                req_accept;
  logic                cfg_accept;
  logic                timeout_hit;
  logic                unused_status;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  assign tx_busy       = st_reg_rdata[TX_BUSY_BIT];
  assign unused_status = ^st_reg_rdata;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant_vec)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) grant_idx = ID_W'(i);
    end
  end

  // Next state and outputs. The handshakes are held off while arst is high so
  // every output shows its reset value for as long as reset is asserted.
  always_comb begin
    state_next    = state_reg;
    req_ready     = '0;
    cfg_ready     = 1'b0;
    ctl_reg_we    = 1'b0;
    ctl_reg_wdata = '0;
    ctl_reg_wmask = '0;
    case (state_reg)
      ST_IDLE: begin
        cfg_ready = ~arst;
        if (cfg_valid) begin
          state_next = ST_CFG;
        end else if (|req_valid && !arst) begin
          req_ready  = grant_vec;
          state_next = ST_LOAD;
        end
      end
      ST_CFG: begin
        ctl_reg_we    = 1'b1;
        ctl_reg_wdata = cfg_word(shadow_reg);
        ctl_reg_wmask = CFG_WMASK;
        state_next    = ST_IDLE;
      end
      ST_LOAD: begin
        ctl_reg_we    = 1'b1;
        ctl_reg_wdata = load_word(shadow_reg, byte_reg);
        ctl_reg_wmask = LOAD_WMASK;
        state_next    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = ST_WAIT_DONE;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_accept = |req_ready;
  assign cfg_accept = cfg_valid & cfg_ready;

  // Pointer starts at the last requester so requester 0 wins the first grant.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= ID_W'(NUM_REQ - 1);
      grant_id_reg <= '0;
      byte_reg     <= '0;
      shadow_reg   <= DEFAULT_CFG;
    end else begin
      state_reg <= state_next;
      if (cfg_accept) begin
        shadow_reg <= '{baud: cfg_baud, stop: cfg_stop, parity: cfg_parity, frame: cfg_frame};
      end
      if (req_accept) begin
        ptr_reg      <= grant_idx;
        grant_id_reg <= grant_idx;
        byte_reg     <= req_byte[grant_idx];
      end
    end
  end

`ifdef UART_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_err_reg;

  // Counts completed WAIT_BUSY cycles; the last allowed cycle without busy
  // seen is the one where the count reaches TIMEOUT_CYCLES-1.
  assign timeout_hit = (state_reg == ST_WAIT_BUSY) && !tx_busy &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      if (state_reg == ST_WAIT_BUSY) cnt_reg <= cnt_reg + 1'b1;
      else                           cnt_reg <= '0;
      if (timeout_hit) timeout_err_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign grant_id     = grant_id_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign st_reg_re    = 1'b1;
  assign st_reg_rmask = 12'hFFF;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
module tb_uart_tx_sequencer;

  localparam int N   = 4;
  localparam int BB  = 3;
  localparam int TMO = 16;
  localparam logic [18:0] LOAD_MASK = 19'h7FC01;
  localparam logic [18:0] CFG_MASK  = 19'h003FF;

  logic           clk = 1'b0;
  logic           arst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           cfg_valid;
  logic [3:0]     cfg_baud;
  logic           cfg_stop;
  logic [1:0]     cfg_parity;
  logic [1:0]     cfg_frame;
  logic           cfg_ready;
  logic           ctl_reg_we;
  logic [18:0]    ctl_reg_wdata;
  logic [18:0]    ctl_reg_wmask;
  logic           st_reg_re;
  logic [11:0]    st_reg_rmask;
  logic [11:0]    st_reg_rdata;
  logic           busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_sequencer #(
    .NUM_REQ        (N),
    .TX_BUSY_BIT    (BB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .grant_id      (grant_id),
    .cfg_valid     (cfg_valid),
    .cfg_baud      (cfg_baud),
    .cfg_stop      (cfg_stop),
    .cfg_parity    (cfg_parity),
    .cfg_frame     (cfg_frame),
    .cfg_ready     (cfg_ready),
    .ctl_reg_we    (ctl_reg_we),
    .ctl_reg_wdata (ctl_reg_wdata),
    .ctl_reg_wmask (ctl_reg_wmask),
    .st_reg_re     (st_reg_re),
    .st_reg_rmask  (st_reg_rmask),
    .st_reg_rdata  (st_reg_rdata),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [18:0] data;
    logic [18:0] mask;
  } wr_t;

  wr_t exp_q[$];
  int  grant_log[$];

  // Reference model state: round-robin pointer and line configuration.
  int m_ptr;
  int m_baud, m_stop, m_par, m_frame;

  bit mute;     // when set, the bench drives the tx-busy bit by hand
  bit man_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] m_cfg_word();
    return 19'(m_baud * 64 + m_stop * 32 + m_par * 8 + m_frame * 2 + 1);
  endfunction

  function automatic logic [18:0] m_load_word(input int b);
    return 19'(b * 2048 + 1024 + m_baud * 64 + m_stop * 32 + m_par * 8 + m_frame * 2 + 1);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Write-port scoreboard monitor.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (ctl_reg_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: wdata %0h wmask %0h with nothing expected", ctl_reg_wdata, ctl_reg_wmask);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", 32'(ctl_reg_wdata), 32'(e.data));
          check("wr_mask", 32'(ctl_reg_wmask), 32'(e.mask));
        end
      end else if (ctl_reg_wdata !== 19'h0 || ctl_reg_wmask !== 19'h0) begin
        miscompares++;
        $display("FAIL idle_bus: wdata %0h wmask %0h while we=0", ctl_reg_wdata, ctl_reg_wmask);
      end
    end
  end

  // UART status model: after a LOAD write, busy rises after 1..4 cycles and
  // stays high 1..5 cycles. Other status bits carry random noise.
  initial begin
    int dly, hold;
    bit bitv;
    logic [11:0] tmp;
    dly = 0; hold = 0; bitv = 1'b0;
    st_reg_rdata = 12'h0;
    forever begin
      @(negedge clk);
      if (mute || arst) begin
        dly = 0; hold = 0;
        bitv = mute ? man_bit : 1'b0;
      end else if (ctl_reg_we === 1'b1 && ctl_reg_wmask === LOAD_MASK) begin
        dly  = $urandom_range(1, 4);
        hold = $urandom_range(1, 5);
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) bitv = 1'b1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) bitv = 1'b0;
      end
      tmp = 12'($urandom);
      tmp[BB] = bitv;
      st_reg_rdata = tmp;
    end
  end

  task automatic issue_cfg(input int b, input int s, input int p, input int f);
    m_baud = b; m_stop = s; m_par = p; m_frame = f;
    cfg_baud = 4'(b); cfg_stop = 1'(s); cfg_parity = 2'(p); cfg_frame = 2'(f);
    cfg_valid = 1'b1;
    exp_q.push_back('{data: m_cfg_word(), mask: CFG_MASK});
  endtask

  // Present mask of requests (called between negedge and posedge); each
  // requester drops valid after its ready pulse. Returns in the LOAD cycle of
  // the final grant.
  task automatic run_reqs(input logic [N-1:0] mask, input logic [8*N-1:0] data, input int budget);
    logic [N-1:0] pend;
    int cyc, pick, last;
    bit chk_gid;
    pend = mask; cyc = 0; chk_gid = 0; last = 0;
    req_data = data;
    req_valid = pend;
    #1;
    if (cfg_valid) check("cfg_beats_req", 32'(req_ready), 32'h0);
    while ((pend != '0 || chk_gid) && cyc < budget) begin
      if (req_ready != '0) begin
        pick = rr_pick(pend, m_ptr);
        check("req_ready", 32'(req_ready), 32'(1 << pick));
        check("grant_when_idle", 32'(busy), 32'h0);
        exp_q.push_back('{data: m_load_word(int'(data[8*pick +: 8])), mask: LOAD_MASK});
        grant_log.push_back(pick);
        m_ptr = pick; last = pick; chk_gid = 1;
        pend[pick] = 1'b0;
      end
      @(posedge clk); #1;
      req_valid = pend;
      cfg_valid = 1'b0;
      @(negedge clk); #1;
      cyc++;
      if (chk_gid && pend == mask - mask) begin
        check("grant_id", 32'(grant_id), 32'(last));
        chk_gid = 0;
      end else if (chk_gid) begin
        check("grant_id", 32'(grant_id), 32'(last));
        chk_gid = 0;
      end
    end
    check("grant_stall", 32'(pend), 32'h0);
    req_valid = '0;
  endtask

  task automatic wait_idle(input int budget);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_idle", 32'(busy), 32'h0);
  endtask

  task automatic reset_model();
    m_ptr = N - 1;
    m_baud = 7; m_stop = 0; m_par = 0; m_frame = 3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(busy),          32'h0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready),     32'h0);
    check({tag, "_req_ready"}, 32'(req_ready),     32'h0);
    check({tag, "_we"},        32'(ctl_reg_we),    32'h0);
    check({tag, "_wdata"},     32'(ctl_reg_wdata), 32'h0);
    check({tag, "_wmask"},     32'(ctl_reg_wmask), 32'h0);
    check({tag, "_grant_id"},  32'(grant_id),      32'h0);
    check({tag, "_tmo"},       32'(timeout_err),   32'h0);
    check({tag, "_st_re"},     32'(st_reg_re),     32'h1);
    check({tag, "_st_rmask"},  32'(st_reg_rmask),  32'hFFF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_order[5];
    logic [8*N-1:0] rd;
    logic [N-1:0] rm;
    exp_order = '{0, 1, 2, 3, 0};
    arst = 1'b1; req_valid = '0; req_data = '0; cfg_valid = 1'b0;
    cfg_baud = '0; cfg_stop = 1'b0; cfg_parity = '0; cfg_frame = '0;
    mute = 1'b0; man_bit = 1'b0;
    reset_model();

    // Reset state while reset is held, with a request pending.
    req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    req_valid = '0;
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk); #1;
    check("idle_cfg_ready", 32'(cfg_ready), 32'h1);

    // Configuration write with known image.
    issue_cfg(13, 1, 1, 3);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("cfg_ready_low", 32'(cfg_ready), 32'h0);
    check("cfg_wdata_const", 32'(ctl_reg_wdata), 32'h0036F);
    @(posedge clk); #1;
    check("cfg_ready_back", 32'(cfg_ready), 32'h1);

    // Single byte with hand-driven status bit.
    @(negedge clk);
    mute = 1'b1; man_bit = 1'b0;
    rd = '0; rd[7:0] = 8'hA5;
    run_reqs(4'b0001, rd, 20);
    check("load_wdata_const", 32'(ctl_reg_wdata), 32'h52F6F);
    check("load_wmask_const", 32'(ctl_reg_wmask), 32'h7FC01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("busy_wait_rise", 32'(busy), 32'h1);
    end
    man_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("busy_wait_fall", 32'(busy), 32'h1);
    end
    man_bit = 1'b0;
    wait_idle(6);
    mute = 1'b0;

    // Configuration and request in the same cycle: CFG write goes first.
    @(negedge clk);
    issue_cfg($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3));
    run_reqs(4'b0100, {$urandom, $urandom} >> 32, 40);
    wait_idle(40);

    // WAIT_BUSY with the busy bit stuck low.
    @(negedge clk);
    mute = 1'b1; man_bit = 1'b0;
    run_reqs(4'b0010, 32'($urandom), 20);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (busy) n++;
      else break;
    end
`ifdef UART_SEQ_TIMEOUT_EN
    check("timeout_cycles", 32'(n), 32'(TMO));
    check("timeout_err", 32'(timeout_err), 32'h1);
    mute = 1'b0;
    @(negedge clk);
    run_reqs(4'b1000, 32'($urandom), 20);
    wait_idle(40);
    check("timeout_sticky", 32'(timeout_err), 32'h1);
`else
    check("no_timeout_stays", 32'(n), 32'd40);
    check("no_timeout_err", 32'(timeout_err), 32'h0);
    man_bit = 1'b1;
    repeat (3) @(negedge clk);
    man_bit = 1'b0;
    wait_idle(10);
    mute = 1'b0;
`endif

    // Reset during WAIT_DONE.
    @(negedge clk);
    mute = 1'b1; man_bit = 1'b0;
    run_reqs(4'b0100, 32'($urandom), 20);
    @(negedge clk); #1;
    man_bit = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'h1);
    #2;
    arst = 1'b1;
    man_bit = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    arst = 1'b0;
    mute = 1'b0;
    reset_model();
    check("no_pending_write", 32'(exp_q.size()), 32'h0);

    // Four simultaneous requesters, then requester 0 again.
    @(negedge clk);
    grant_log.delete();
    run_reqs(4'b1111, {$urandom}, 200);
    wait_idle(40);
    run_reqs(4'b0001, 32'($urandom), 20);
    wait_idle(40);
    check("order_len", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check("grant_order", 32'(grant_log[i]), 32'(exp_order[i]));
    end

    // Randomized traffic with occasional concurrent configuration.
    for (int it = 0; it < 25; it++) begin
      @(negedge clk);
      rm = 4'($urandom_range(1, 15));
      rd = {$urandom};
      if ($urandom_range(0, 2) == 0)
        issue_cfg($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3));
      run_reqs(rm, rd, 200);
      wait_idle(40);
    end

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
